// File: rtl/tile_scroll_engine_pkg.sv
// Shared sizes, saturation limits and FSM encoding for the piano-game tile scroll engine.
package tile_scroll_engine_pkg;
  localparam int LANES     = 4;
  localparam int ROWS      = 8;
  localparam int MAX_MISS  = 5;
  localparam int SCORE_MAX = 9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  function automatic logic [2:0] popcount3(input logic [LANES-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < LANES; i++) n = n + {2'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/tile_scroll_engine_tick_step_counter.sv
// Rising-edge detect on the 100 Hz reference and a modulo-STEP_TICKS tick counter.
module tick_step_counter #(
  parameter int STEP_TICKS = 25
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clk_100,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick,
  output logic o_step
);
  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  logic          r_c100_q;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign o_tick = i_clk_100 & ~r_c100_q;
  assign w_last = (r_cnt == CW'(STEP_TICKS - 1));
  assign o_step = i_en & o_tick & w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c100_q <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_c100_q <= i_clk_100;
      if (i_clr)              r_cnt <= '0;
      else if (i_en && o_tick) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/tile_scroll_engine.sv
// Game-tick engine: scrolls tiles down LANES x ROWS, accepts new top rows, judges key presses on row 0.
module tile_scroll_engine
  import tile_scroll_engine_pkg::*;
#(
  parameter int STEP_TICKS = 25
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clk_100,
  input  logic                  i_start,
  input  logic [LANES-1:0]      i_key_pulse,
  input  logic [LANES-1:0]      i_pat_data,
  input  logic                  i_pat_valid,
  output logic                  o_pat_ready,
  output logic [LANES*ROWS-1:0] o_lanes,
  output logic [13:0]           o_score,
  output logic [2:0]            o_miss_cnt,
  output logic                  o_game_over
);
  state_t                       r_state, w_state_nxt;
  logic [ROWS-1:0][LANES-1:0]   r_lanes, w_lanes_nxt;
  logic [13:0]                  r_score, w_score_nxt;
  logic [2:0]                   r_miss, w_miss_nxt;

  logic             w_run, w_clr, w_tick, w_step_raw, w_step;
  logic [LANES-1:0] w_row0, w_hit, w_wrong;
  logic [2:0]       w_pop;
  logic [14:0]      w_score_sum;
  logic [1:0]       w_miss_inc;
  logic [3:0]       w_miss_sum;

  assign w_run = (r_state == ST_RUN);
  assign w_clr = i_start & ~w_run;

  tick_step_counter #(.STEP_TICKS(STEP_TICKS)) u_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clk_100 (i_clk_100),
    .i_en      (w_run),
    .i_clr     (w_clr),
    .o_tick    (w_tick),
    .o_step    (w_step_raw)
  );

  // A step is only ever a tick that also wraps the counter.
  assign w_step = w_tick & w_step_raw;

  assign w_row0      = r_lanes[0];
  assign w_hit       = i_key_pulse & w_row0;
  assign w_wrong     = i_key_pulse & ~w_row0;
  assign w_pop       = popcount3(w_hit);
  assign w_score_sum = {1'b0, r_score} + {12'd0, w_pop};
  assign w_score_nxt = (w_score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : w_score_sum[13:0];
  // Wrong key and a tile scrolling off unhit are independent misses.
  assign w_miss_inc  = {1'b0, |w_wrong} + {1'b0, w_step & (|(w_row0 & ~w_hit))};
  assign w_miss_sum  = {1'b0, r_miss} + {2'd0, w_miss_inc};
  assign w_miss_nxt  = (w_miss_sum >= 4'(MAX_MISS)) ? 3'(MAX_MISS) : w_miss_sum[2:0];

  always_comb begin
    w_lanes_nxt    = r_lanes;
    w_lanes_nxt[0] = w_row0 & ~w_hit;
    if (w_step) begin
      for (int i = 0; i < ROWS - 1; i++) w_lanes_nxt[i] = r_lanes[i+1];
      w_lanes_nxt[ROWS-1] = i_pat_valid ? i_pat_data : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_OVER: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN:           if (w_miss_nxt == 3'(MAX_MISS)) w_state_nxt = ST_OVER;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_clr) begin
      r_lanes <= '0;
      r_score <= '0;
      r_miss  <= '0;
    end else if (w_run) begin
      r_lanes <= w_lanes_nxt;
      r_score <= w_score_nxt;
      r_miss  <= w_miss_nxt;
    end
  end

  assign o_pat_ready = w_step;
  assign o_lanes     = r_lanes;
  assign o_score     = r_score;
  assign o_miss_cnt  = r_miss;
  assign o_game_over = (r_state == ST_OVER);
endmodule

// File: tb/tb_tile_scroll_engine.sv
// Directed bench for tile_scroll_engine with a per-cycle behavioural model and literal spot checks.
module tb_tile_scroll_engine;
  localparam int ST = 2;
  localparam int NL = 4;
  localparam int NR = 8;

  logic              clk = 1'b0, rst = 1'b1, clk_100 = 1'b0, start = 1'b0, pat_valid = 1'b0;
  logic [NL-1:0]     key = '0, pat = '0;
  logic              pat_ready, game_over;
  logic [NL*NR-1:0]  lanes;
  logic [13:0]       score;
  logic [2:0]        miss_cnt;

  tile_scroll_engine #(.STEP_TICKS(ST)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_100(clk_100), .i_start(start),
    .i_key_pulse(key), .i_pat_data(pat), .i_pat_valid(pat_valid),
    .o_pat_ready(pat_ready), .o_lanes(lanes), .o_score(score),
    .o_miss_cnt(miss_cnt), .o_game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int phase = 0, per = 20, rdy_cnt = 0;
  bit chk_en = 1'b0;

  // Model state: 0 idle, 1 run, 2 over
  logic [NR-1:0][NL-1:0] m_lanes = '0;
  int m_score = 0, m_miss = 0, m_cnt = 0, m_state = 0, m_steps = 0;
  bit m_q = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_step_now();
    return (m_state == 1) && clk_100 && !m_q && (m_cnt == ST - 1);
  endfunction

  task automatic model_edge();
    bit stp, tick;
    logic [NL-1:0] row0, hit, wrong;
    int nm;
    if (rst) begin
      m_lanes = '0; m_score = 0; m_miss = 0; m_cnt = 0; m_state = 0; m_q = 1'b0;
      return;
    end
    stp  = m_step_now();
    tick = clk_100 && !m_q;
    m_q  = clk_100;
    if (m_state != 1) begin
      if (start) begin
        m_lanes = '0; m_score = 0; m_miss = 0; m_cnt = 0; m_state = 1;
      end
    end else begin
      if (tick) m_cnt = (m_cnt + 1) % ST;
      row0  = m_lanes[0];
      hit   = key & row0;
      wrong = key & ~row0;
      nm    = ((wrong != 0) ? 1 : 0) + ((stp && ((row0 & ~hit) != 0)) ? 1 : 0);
      m_score = m_score + $countones(hit);
      if (m_score > 9999) m_score = 9999;
      m_miss = m_miss + nm;
      if (m_miss > 5) m_miss = 5;
      m_lanes[0] = row0 & ~hit;
      if (stp) begin
        m_lanes = {(pat_valid ? pat : 4'h0), m_lanes[NR-1:1]};
        m_steps++;
      end
      if (m_miss == 5) m_state = 2;
    end
  endtask

  always @(posedge clk) model_edge();

  always @(negedge clk) begin
    if (chk_en) begin
      check("lanes", lanes, m_lanes);
      check("score", score, m_score);
      check("miss_cnt", miss_cnt, m_miss);
      check("game_over", game_over, m_state == 2);
      check("pat_ready", pat_ready, m_step_now());
      if (pat_ready === 1'b1) rdy_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    phase++;
    clk_100 = ((phase % per) < per / 2);
  endtask

  task automatic run_steps(input int n);
    int target, g;
    target = m_steps + n;
    g = 0;
    while (m_steps < target && g < 20000) begin cyc(); g++; end
    if (m_steps < target) check("step_timeout", 0, 1);
  endtask

  task automatic load_row(input logic [NL-1:0] d);
    pat_valid = 1'b1; pat = d;
    run_steps(1);
    pat_valid = 1'b0; pat = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  initial begin
    int g;
    cyc(); chk_en = 1'b1; cyc();
    rst = 1'b0;
    check("rst_lanes", lanes, 0);
    check("rst_score", score, 0);
    check("rst_miss", miss_cnt, 0);
    check("rst_over", game_over, 0);
    rdy_cnt = 0;
    repeat (60) cyc();
    check("idle_no_ready", rdy_cnt, 0);

    // Scroll a single tile from the top to row 0
    pulse_start();
    rdy_cnt = 0;
    load_row(4'b0001);
    run_steps(7);
    check("scroll_row0", lanes, 32'h0000_0001);
    check("ready_pulses", rdy_cnt, 8);

    key = 4'b0001; cyc(); key = '0;
    check("hit_score", score, 1);
    check("hit_clear", lanes, 0);
    check("hit_miss", miss_cnt, 0);

    // Hit coinciding with a step
    load_row(4'b0001);
    run_steps(7);
    g = 0;
    while (!m_step_now() && g < 200) begin cyc(); g++; end
    check("await_step", m_step_now(), 1);
    key = 4'b0001; cyc(); key = '0;
    check("step_hit_score", score, 2);
    check("step_hit_miss", miss_cnt, 0);
    check("step_hit_lanes", lanes, 0);

    key = 4'b0010; cyc(); key = '0;
    check("wrong_miss", miss_cnt, 1);
    load_row(4'b1000);
    run_steps(8);
    check("unhit_miss", miss_cnt, 2);
    check("unhit_lanes", lanes, 0);

    key = 4'b0010; cyc(); cyc();
    check("miss4", miss_cnt, 4);
    check("not_over", game_over, 0);
    cyc();
    check("miss5", miss_cnt, 5);
    check("over", game_over, 1);

    key = 4'b1111; pat_valid = 1'b1; pat = 4'b1111;
    repeat (100) cyc();
    key = '0; pat_valid = 1'b0; pat = '0;
    check("frozen_score", score, 2);
    check("frozen_lanes", lanes, 0);
    check("frozen_miss", miss_cnt, 5);

    pulse_start();
    check("restart_over", game_over, 0);
    check("restart_score", score, 0);
    check("restart_miss", miss_cnt, 0);

    // Fast clk_100 and full rows to drive the score into saturation
    per = 2;
    pat_valid = 1'b1; pat = 4'b1111;
    g = 0;
    while (m_score < 9999 && g < 30000) begin
      key = (m_lanes[0] == 4'hF && !m_step_now()) ? 4'hF : 4'h0;
      cyc(); g++;
    end
    repeat (40) begin
      key = (m_lanes[0] == 4'hF && !m_step_now()) ? 4'hF : 4'h0;
      cyc();
    end
    key = '0;
    check("sat_score", score, 9999);
    check("sat_miss", miss_cnt, 0);

    rst = 1'b1; cyc(); rst = 1'b0;
    pat_valid = 1'b0; pat = '0;
    check("midrst_lanes", lanes, 0);
    check("midrst_score", score, 0);
    check("midrst_miss", miss_cnt, 0);
    check("midrst_over", game_over, 0);
    repeat (10) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
